// File: rtl/rf_arb_pkg.sv
// Shared types and sizing for the register-file port arbiter.
//   XLEN       : datapath width
//   RF_ADDR_W  : register address width
//   WB_DEPTH   : writeback buffer entries (power of two)
//   wb_entry_t : one buffered writeback (addr, data)
//   grant_e    : which requester owns the port this cycle
package rf_arb_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned WB_DEPTH  = 2;
  localparam int unsigned PTR_W     = $clog2(WB_DEPTH);

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WR,
    GNT_RD
  } grant_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// In-order writeback buffer with per-entry address compare.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   push, push_entry : enqueue (caller guarantees !full)
//   pop            : dequeue head (caller guarantees !empty)
//   full, empty    : occupancy flags
//   head           : oldest entry
//   cmp_addr, hit  : hit=1 when any valid entry holds cmp_addr
module rf_wb_fifo
  import rf_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  wb_entry_t            push_entry,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output wb_entry_t            head,
  input  logic [RF_ADDR_W-1:0] cmp_addr,
  output logic                 hit
);

  wb_entry_t            mem [WB_DEPTH];
  logic [WB_DEPTH-1:0]  vld;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;

  // Per-slot valid bits make full/empty a single lookup at the pointers.
  assign full  = vld[wr_ptr];
  assign empty = ~vld[rd_ptr];
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      if (vld[i] && (mem[i].addr == cmp_addr)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares one register-file port between operand reads and buffered ALU
// writebacks, and captures read data into operand registers op_a/op_b.
// Ports:
//   clk, reset_n                      : clock, synchronous active-low reset
//   rd_req/rd_addr/rd_sel/rd_ready    : operand read handshake
//   wb_req/wb_addr/wb_data/wb_ready   : writeback handshake
//   rf_en/rf_we/rf_addr/rf_wdata      : register file port
//   rf_rdata                          : port read data, one cycle after issue
//   op_a/op_b, op_a_valid/op_b_valid  : captured operands
//   op_clr                            : clears both valids
// Build option: RF_ARB_RR_EN selects round-robin read/write arbitration;
// undefined gives fixed write priority.
module rf_port_arbiter
  import rf_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rd_req,
  input  logic [RF_ADDR_W-1:0] rd_addr,
  input  logic                 rd_sel,
  output logic                 rd_ready,
  input  logic                 wb_req,
  input  logic [RF_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 wb_ready,
  output logic                 rf_en,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_addr,
  output logic [XLEN-1:0]      rf_wdata,
  input  logic [XLEN-1:0]      rf_rdata,
  output logic [XLEN-1:0]      op_a,
  output logic [XLEN-1:0]      op_b,
  output logic                 op_a_valid,
  output logic                 op_b_valid,
  input  logic                 op_clr
);

  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_hit;
  logic      push;
  logic      pop;
  wb_entry_t head;
  wb_entry_t push_entry;
  logic      rd_zero;
  logic      rd_cand;
  logic      wr_cand;
  grant_e    gnt;
  logic      cap_vld;
  logic      cap_sel;
  logic      cap_zero;

  assign rd_zero  = (rd_addr == '0);
  assign wb_ready = reset_n & ~fifo_full;
  // Writes to r0 are acknowledged but never buffered.
  assign push     = wb_req & wb_ready & (wb_addr != '0);
  assign push_entry = '{addr: wb_addr, data: wb_data};

  assign wr_cand = reset_n & ~fifo_empty;
  assign rd_cand = reset_n & rd_req & ~rd_zero & ~fifo_hit;

  rf_wb_fifo u_wb_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head),
    .cmp_addr   (rd_addr),
    .hit        (fifo_hit)
  );

`ifdef RF_ARB_RR_EN
  logic last_rd;

  always_ff @(posedge clk) begin
    if (!reset_n)             last_rd <= 1'b1;
    else if (gnt != GNT_NONE) last_rd <= (gnt == GNT_RD);
  end
`endif

  always_comb begin
    gnt = GNT_NONE;
    if (wr_cand && rd_cand) begin
`ifdef RF_ARB_RR_EN
      gnt = (fifo_full || last_rd) ? GNT_WR : GNT_RD;
`else
      gnt = GNT_WR;
`endif
    end else if (wr_cand) begin
      gnt = GNT_WR;
    end else if (rd_cand) begin
      gnt = GNT_RD;
    end
  end

  always_comb begin
    rf_en    = 1'b0;
    rf_we    = 1'b0;
    rf_addr  = '0;
    rf_wdata = '0;
    pop      = 1'b0;
    case (gnt)
      GNT_WR: begin
        rf_en    = 1'b1;
        rf_we    = 1'b1;
        rf_addr  = head.addr;
        rf_wdata = head.data;
        pop      = 1'b1;
      end
      GNT_RD: begin
        rf_en   = 1'b1;
        rf_addr = rd_addr;
      end
      default: ;
    endcase
  end

  // r0 reads complete without the port, so they are never stalled.
  assign rd_ready = reset_n & rd_req & (rd_zero | (gnt == GNT_RD));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_vld  <= 1'b0;
      cap_sel  <= 1'b0;
      cap_zero <= 1'b0;
    end else begin
      cap_vld  <= rd_ready;
      cap_sel  <= rd_sel;
      cap_zero <= rd_zero;
    end
  end

  // Clear is applied first so a same-edge load keeps its valid set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_a_valid <= 1'b0;
      op_b_valid <= 1'b0;
    end else begin
      if (op_clr) begin
        op_a_valid <= 1'b0;
        op_b_valid <= 1'b0;
      end
      if (cap_vld && !cap_sel) begin
        op_a       <= cap_zero ? '0 : rf_rdata;
        op_a_valid <= 1'b1;
      end
      if (cap_vld && cap_sel) begin
        op_b       <= cap_zero ? '0 : rf_rdata;
        op_b_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
module tb_rf_port_arbiter;
  import rf_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_req;
  logic [4:0]  rd_addr;
  logic        rd_sel;
  logic        rd_ready;
  logic        wb_req;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        rf_en;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_a_valid;
  logic        op_b_valid;
  logic        op_clr;

  always #5 clk = ~clk;

  rf_port_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_sel     (rd_sel),
    .rd_ready   (rd_ready),
    .wb_req     (wb_req),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .rf_en      (rf_en),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
    .rf_rdata   (rf_rdata),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_a_valid (op_a_valid),
    .op_b_valid (op_b_valid),
    .op_clr     (op_clr)
  );

  typedef struct {
    logic        sel;
    logic [31:0] val;
    int unsigned due;
  } rd_exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  rd_exp_t     rq[$];
  wr_exp_t     wq[$];
  logic [31:0] mem    [32];
  logic [31:0] shadow [32];
  logic [31:0] next_rdata;
  int unsigned cyc;
  int          occ;
  int          total;
  int          bad;

  // Register-file model plus scoreboard; samples at the falling edge.
  task mon();
    rd_exp_t e;
    wr_exp_t w;
    logic    haz;
    @(negedge clk);
    while (rq.size() > 0 && rq[0].due <= cyc) begin
      e = rq.pop_front();
      total++;
      if (e.sel) begin
        if (op_b !== e.val || op_b_valid !== 1'b1) begin
          bad++;
          $display("FAIL op_b_load: got %h/%b want %h/1", op_b, op_b_valid, e.val);
        end
      end else begin
        if (op_a !== e.val || op_a_valid !== 1'b1) begin
          bad++;
          $display("FAIL op_a_load: got %h/%b want %h/1", op_a, op_a_valid, e.val);
        end
      end
    end
    next_rdata = 32'hDEAD_0000 + cyc;
    if (!reset_n) begin
      total++;
      if ({rd_ready, wb_ready, rf_en, rf_we} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_gate: got rd/wb/en/we=%b want 0000",
                 {rd_ready, wb_ready, rf_en, rf_we});
      end
      rq.delete();
      wq.delete();
      occ = 0;
      for (int i = 0; i < 32; i++) shadow[i] = mem[i];
      return;
    end
    total++;
    if (wb_ready !== (occ < 2)) begin
      bad++;
      $display("FAIL wb_ready: got %b want %b (occ=%0d)", wb_ready, (occ < 2), occ);
    end
    haz = 1'b0;
    foreach (wq[i]) if (wq[i].addr == rd_addr) haz = 1'b1;
    if (rd_req && rd_addr != 5'd0 && haz) begin
      total++;
      if (rd_ready !== 1'b0) begin
        bad++;
        $display("FAIL hazard: rd_ready got %b want 0 (addr %0d)", rd_ready, rd_addr);
      end
    end
`ifndef RF_ARB_RR_EN
    if (rd_req && rd_addr != 5'd0 && occ > 0) begin
      total++;
      if (rd_ready !== 1'b0 || rf_we !== 1'b1) begin
        bad++;
        $display("FAIL wr_priority: rd_ready/rf_we got %b%b want 01", rd_ready, rf_we);
      end
    end
`endif
    total++;
    if (!rf_en) begin
      if ({rf_we, rf_addr, rf_wdata} !== 38'd0) begin
        bad++;
        $display("FAIL idle_port: got we=%b addr=%h wdata=%h want 0", rf_we, rf_addr, rf_wdata);
      end
    end else if (rf_we) begin
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL spurious_write: got addr=%h data=%h want no write", rf_addr, rf_wdata);
      end else begin
        w = wq.pop_front();
        occ--;
        if (rf_addr !== w.addr || rf_wdata !== w.data) begin
          bad++;
          $display("FAIL write_order: got %h/%h want %h/%h", rf_addr, rf_wdata, w.addr, w.data);
        end
      end
      mem[rf_addr] = rf_wdata;
    end else begin
      if (!(rd_req && rd_ready && rd_addr == rf_addr && rd_addr != 5'd0) || rf_wdata !== 32'd0) begin
        bad++;
        $display("FAIL read_issue: got addr=%h rd_ready=%b want addr=%h rd_ready=1",
                 rf_addr, rd_ready, rd_addr);
      end
      next_rdata = mem[rf_addr];
    end
    if (rd_req && rd_ready)
      rq.push_back('{sel: rd_sel, val: (rd_addr == 5'd0) ? 32'd0 : shadow[rd_addr], due: cyc + 2});
    if (wb_req && wb_ready && wb_addr != 5'd0) begin
      wq.push_back('{addr: wb_addr, data: wb_data});
      shadow[wb_addr] = wb_data;
      occ++;
    end
  endtask

  task adv();
    @(posedge clk);
    cyc++;
    #1;
    rf_rdata = next_rdata;
  endtask

  task step();
    mon();
    adv();
  endtask

  task test_reset();
    reset_n = 1'b0;
    rd_req  = 1'b1; rd_addr = 5'd4; rd_sel = 1'b0;
    wb_req  = 1'b1; wb_addr = 5'd2; wb_data = 32'h2222_2222;
    step();
    step();
    rd_req = 1'b0; wb_req = 1'b0; reset_n = 1'b1;
    mon();
    total++;
    if ({op_a, op_b, op_a_valid, op_b_valid, rf_en, rf_we, rf_addr, rf_wdata, rd_ready} !== '0
        || wb_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset: got op_a=%h op_b=%h va=%b vb=%b en=%b wb_ready=%b want zeros, wb_ready=1",
               op_a, op_b, op_a_valid, op_b_valid, rf_en, wb_ready);
    end
    adv();
  endtask

  task test_basic_read();
    rd_req = 1'b1; rd_addr = 5'd5; rd_sel = 1'b0;
    mon();
    total++;
    if ({rd_ready, rf_en, rf_we, rf_addr} !== {1'b1, 1'b1, 1'b0, 5'd5}) begin
      bad++;
      $display("FAIL basic_grant: got rdy=%b en=%b we=%b addr=%h want 1 1 0 05",
               rd_ready, rf_en, rf_we, rf_addr);
    end
    adv();
    rd_req = 1'b0;
    step();
    mon();
    total++;
    if (op_a !== 32'h1234_5678 || op_a_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_op_a: got %h/%b want 12345678/1", op_a, op_a_valid);
    end
    adv();
  endtask

  task test_hazard();
    wb_req = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_00A5;
    step();
    wb_req = 1'b0;
    rd_req = 1'b1; rd_addr = 5'd3; rd_sel = 1'b1;
    mon();
    total++;
    if ({rd_ready, rf_en, rf_we, rf_addr, rf_wdata} !== {1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_00A5}) begin
      bad++;
      $display("FAIL hazard_write: got rdy=%b we=%b addr=%h wdata=%h want 0 1 03 000000a5",
               rd_ready, rf_we, rf_addr, rf_wdata);
    end
    adv();
    mon();
    total++;
    if ({rd_ready, rf_en, rf_we, rf_addr} !== {1'b1, 1'b1, 1'b0, 5'd3}) begin
      bad++;
      $display("FAIL hazard_release: got rdy=%b we=%b addr=%h want 1 0 03", rd_ready, rf_we, rf_addr);
    end
    adv();
    rd_req = 1'b0;
    step();
    mon();
    total++;
    if (op_b !== 32'h0000_00A5 || op_b_valid !== 1'b1) begin
      bad++;
      $display("FAIL hazard_op_b: got %h/%b want 000000a5/1", op_b, op_b_valid);
    end
    adv();
  endtask

  task test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      rd_req = 1'b1; rd_addr = 5'(10 + i); rd_sel = i[0];
      mon();
      total++;
      if (rd_ready !== 1'b1 || rf_addr !== 5'(10 + i)) begin
        bad++;
        $display("FAIL b2b_read: got rdy=%b addr=%h want 1 %h", rd_ready, rf_addr, 5'(10 + i));
      end
      adv();
    end
    rd_req = 1'b0;
    step();
    step();
  endtask

  task test_wb_stream();
    rd_req = 1'b1; rd_addr = 5'd20; rd_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_req = 1'b1; wb_addr = 5'(21 + i); wb_data = 32'hC0DE_0000 + i;
      step();
    end
    wb_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (wq.size() != 0) begin
      bad++;
      $display("FAIL wb_drain: got %0d pending want 0", wq.size());
    end
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1; rd_addr = 5'(21 + i); rd_sel = i[0];
      step();
    end
    rd_req = 1'b0;
    step();
    step();
  endtask

  task test_zero();
    wb_req = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_00FF;
    mon();
    total++;
    if (wb_ready !== 1'b1) begin
      bad++;
      $display("FAIL zero_wb_ready: got %b want 1", wb_ready);
    end
    adv();
    wb_req = 1'b0;
    mon();
    total++;
    if (rf_en !== 1'b0) begin
      bad++;
      $display("FAIL zero_wb_port: got rf_en=%b want 0", rf_en);
    end
    adv();
    rd_req = 1'b1; rd_addr = 5'd0; rd_sel = 1'b1;
    mon();
    total++;
    if (rd_ready !== 1'b1 || rf_en !== 1'b0) begin
      bad++;
      $display("FAIL zero_read: got rdy=%b en=%b want 1 0", rd_ready, rf_en);
    end
    adv();
    rd_req = 1'b0;
    step();
    mon();
    total++;
    if (op_b !== 32'd0 || op_b_valid !== 1'b1) begin
      bad++;
      $display("FAIL zero_op_b: got %h/%b want 00000000/1", op_b, op_b_valid);
    end
    adv();
    wb_req = 1'b1; wb_addr = 5'd4; wb_data = 32'h0000_0044;
    step();
    wb_req = 1'b0;
    rd_req = 1'b1; rd_addr = 5'd0; rd_sel = 1'b0;
    mon();
    total++;
    if ({rd_ready, rf_we, rf_addr} !== {1'b1, 1'b1, 5'd4}) begin
      bad++;
      $display("FAIL zero_read_shares: got rdy=%b we=%b addr=%h want 1 1 04", rd_ready, rf_we, rf_addr);
    end
    adv();
    rd_req = 1'b0;
    step();
    step();
  endtask

  task test_clr();
    rd_req = 1'b1; rd_addr = 5'd7; rd_sel = 1'b0;
    step();
    rd_req = 1'b0; op_clr = 1'b1;
    step();
    op_clr = 1'b0;
    mon();
    total++;
    if (op_a_valid !== 1'b1 || op_b_valid !== 1'b0) begin
      bad++;
      $display("FAIL clr_with_load: got va=%b vb=%b want 1 0", op_a_valid, op_b_valid);
    end
    adv();
    op_clr = 1'b1;
    step();
    op_clr = 1'b0;
    mon();
    total++;
    if (op_a_valid !== 1'b0 || op_b_valid !== 1'b0) begin
      bad++;
      $display("FAIL clr_only: got va=%b vb=%b want 0 0", op_a_valid, op_b_valid);
    end
    adv();
  endtask

  task test_reset_mid_read();
    rd_req = 1'b1; rd_addr = 5'd9; rd_sel = 1'b1;
    wb_req = 1'b1; wb_addr = 5'd11; wb_data = 32'h0000_00BB;
    mon();
    total++;
    if (rd_ready !== 1'b1 || wb_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_grant: got rdy=%b wb_ready=%b want 1 1", rd_ready, wb_ready);
    end
    adv();
    rd_req = 1'b0; wb_req = 1'b0; reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    mon();
    total++;
    if ({op_a, op_b, op_a_valid, op_b_valid, rf_en} !== '0) begin
      bad++;
      $display("FAIL midrst_state: got op_a=%h op_b=%h va=%b vb=%b en=%b want zeros",
               op_a, op_b, op_a_valid, op_b_valid, rf_en);
    end
    adv();
    step();
    step();
    rd_req = 1'b1; rd_addr = 5'd11; rd_sel = 1'b0;
    step();
    rd_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0; cyc = 0; occ = 0;
    rd_req = 1'b0; rd_addr = '0; rd_sel = 1'b0;
    wb_req = 1'b0; wb_addr = '0; wb_data = '0;
    op_clr = 1'b0; rf_rdata = '0; reset_n = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h5A00_0000 + 32'(i * 17);
    mem[0] = 32'd0;
    mem[5] = 32'h1234_5678;
    for (int i = 0; i < 32; i++) shadow[i] = mem[i];
    test_reset();
    test_basic_read();
    test_hazard();
    test_back_to_back();
    test_wb_stream();
    test_zero();
    test_clr();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_port_arbiter.md
RF_PORT_ARBITER -- requirements
Module: rf_port_arbiter

Interface
REQ-001 Ports, one per line (name  direction  width  meaning); one clock; reset is synchronous and active-low:
  clk  in  1  sole clock, rising edge
  reset_n  in  1  synchronous active-low reset
  rd_req  in  1  operand read request from decoder
  rd_addr  in  5  register to read
  rd_sel  in  1  destination: 0 op_a, 1 op_b
  rd_ready  out  1  read accepted this cycle
  wb_req  in  1  ALU writeback request
  wb_addr  in  5  writeback register
  wb_data  in  32  writeback data
  wb_ready  out  1  writeback accepted this cycle
  rf_en  out  1  register file port enable
  rf_we  out  1  port write enable
  rf_addr  out  5  port address
  rf_wdata  out  32  port write data
  rf_rdata  in  32  port read data, valid cycle after read issue
  op_a  out  32  captured operand A
  op_b  out  32  captured operand B
  op_a_valid  out  1  op_a holds fresh data
  op_b_valid  out  1  op_b holds fresh data
  op_clr  in  1  ALU done; clears both valids

Function
REQ-002 Writebacks SHALL enter a 2-entry in-order buffer on wb_req && wb_ready; wb_ready = buffer not full (current-cycle occupancy, no push-through when full).
REQ-003 Writeback to address 0 SHALL be accepted (wb_ready per REQ-002) and discarded, never pushed.
REQ-004 Each cycle the port SHALL carry at most one access: buffer-head write (rf_en=1, rf_we=1, head addr/data, pop) or read (rf_en=1, rf_we=0, rf_addr=rd_addr).
REQ-005 Read hazard: rd_req whose nonzero rd_addr matches any valid buffer entry SHALL NOT be granted (rd_ready=0) until that entry retires.
REQ-006 Read of address 0 SHALL complete without port use (rd_ready=1, rf_en not driven by it); port SHALL be free for a buffered write that cycle.
REQ-007 Arbitration (default): buffer non-empty -> write granted; else hazard-free rd_req granted.
REQ-008 Granted read: rf_rdata (or 0 for address 0) SHALL load op_a/op_b per captured rd_sel exactly one cycle after rd_ready, and set corresponding valid same edge.
REQ-009 Reads SHALL pipeline back-to-back: one read per cycle sustained when no writes pending.
REQ-010 op_clr SHALL clear both valids next edge; a simultaneous operand load wins for the operand being loaded.
REQ-011 Simultaneous push and pop SHALL keep occupancy constant and preserve order.
REQ-012 When idle, rf_en=0, rf_we=0, rf_addr=0, rf_wdata=0.

Reset
REQ-013 reset_n low at a clk edge SHALL empty buffer, drop any in-flight read capture, clear op_a, op_b, both valids, and round-robin flag.
REQ-014 While reset_n low, rd_ready, wb_ready, rf_en, rf_we SHALL be 0; all outputs 0 first cycle after reset.
REQ-015 Reset mid-read SHALL suppress the pending operand load.

Configuration
REQ-016 RF_ARB_RR_EN defined: when both a buffered write and a hazard-free read are pending, grant SHALL alternate via a last-grant flag (flag reset to "read last", so write first); buffer full SHALL still force write.
REQ-017 RF_ARB_RR_EN undefined: fixed write priority per REQ-007; flag logic absent.

Structure
REQ-018 Package rf_arb_pkg SHALL hold XLEN=32, RF_ADDR_W=5, WB_DEPTH=2 and the writeback entry struct (addr, data).
REQ-019 Buffer SHALL be sub-module rf_wb_fifo (push/pop/full/empty, entry compare outputs for hazard check).

Verification
REQ-020 Reset then rd_req addr 5 sel 0, rf_rdata=0x1234_5678 -> rd_ready=1 cycle 1, op_a=0x12345678, op_a_valid=1 cycle 2.
REQ-021 wb_req addr 3 data 0xA5 then rd_req addr 3 next cycle -> rd_ready=0 until write issued (rf_we=1, rf_addr=3, rf_wdata=0xA5), read granted cycle after.
REQ-022 Three wb_req cycles back-to-back while reads hold port (RR build) -> third sees wb_ready=0 only when 2 entries held; order of rf_wdata preserved.
REQ-023 wb_req addr 0 data 0xFF -> wb_ready=1, no rf_we; rd addr 0 sel 1 -> op_b=0, op_b_valid=1, rf_en=0.
REQ-024 op_clr with simultaneous op_a load -> op_a_valid=1, op_b_valid=0.
REQ-025 reset_n low one cycle after read grant -> no operand load, valids 0, buffer empty.
